// File: rtl/seg_scan_driver_pkg.sv
// Shared types, constants and the hex-to-segment decoder for the seven-segment scan driver.
// Segment vectors are active-low {a,b,c,d,e,f,g} with a in bit 6.
package seg_scan_driver_pkg;

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_ZERO = 7'b0000001;

  // One digit's worth of display state; raw/lz are replicated per digit by the writer.
  typedef struct packed {
    logic [3:0] hex;
    logic [6:0] segs;
    logic       dp;
    logic       en;
    logic       raw;
    logic       lz;
  } disp_cfg_t;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = SEG_ZERO;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Write port, live brightness and board pin outputs of the scan driver.
// master = host/bench side, slave = the driver.
interface seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8,
  parameter int BRIGHT_W   = 4
);
  logic                    wr_valid;
  logic [NUM_DIGITS*4-1:0] wr_hex;
  logic [NUM_DIGITS*7-1:0] wr_segs;
  logic [NUM_DIGITS-1:0]   wr_dp;
  logic [NUM_DIGITS-1:0]   wr_en;
  logic                    wr_raw;
  logic                    wr_lz;
  logic [BRIGHT_W-1:0]     brightness;
  logic [NUM_DIGITS-1:0]   AN;
  logic [6:0]              A2G;
  logic                    DP;
  logic                    frame_start;

  modport master (
    output wr_valid, wr_hex, wr_segs, wr_dp, wr_en, wr_raw, wr_lz, brightness,
    input  AN, A2G, DP, frame_start
  );

  modport slave (
    input  wr_valid, wr_hex, wr_segs, wr_dp, wr_en, wr_raw, wr_lz, brightness,
    output AN, A2G, DP, frame_start
  );
endinterface

// File: rtl/seg_scan_driver_timer.sv
// Slot/cycle/PWM counters for the scan driver; flags the blank window and the frame boundary,
// and emits frame_start registered so it lines up with the registered pin outputs.
module seg_scan_driver_timer #(
  parameter int  NUM_DIGITS   = 8,
  parameter int  DIGIT_CYCLES = 131072,
  parameter int  BLANK_CYCLES = 1024,
  parameter int  BRIGHT_W     = 4,
  localparam int SLOT_W       = $clog2(NUM_DIGITS),
  localparam int CYC_W        = $clog2(DIGIT_CYCLES)
) (
  input  logic                clk,
  input  logic                reset,
  output logic [SLOT_W-1:0]   o_slot,
  output logic [BRIGHT_W-1:0] o_pwm,
  output logic                o_blank,
  output logic                o_boundary,
  output logic                o_frame_start
);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(DIGIT_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  logic [CYC_W-1:0]    r_cyc;
  logic [SLOT_W-1:0]   r_slot;
  logic [BRIGHT_W-1:0] r_pwm;
  logic                r_frame_start;
  logic                w_cyc_last;
  logic                w_slot_last;

  assign w_cyc_last  = (r_cyc == CYC_LAST);
  assign w_slot_last = (r_slot == SLOT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc         <= '0;
      r_slot        <= '0;
      r_pwm         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_pwm         <= r_pwm + 1'b1;
      r_frame_start <= (r_cyc == '0) && (r_slot == '0);
      if (w_cyc_last) begin
        r_cyc  <= '0;
        // Explicit wrap so non-power-of-two digit counts work.
        r_slot <= w_slot_last ? '0 : r_slot + 1'b1;
      end else begin
        r_cyc <= r_cyc + 1'b1;
      end
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign o_blank = 1'b0;
    end else begin : g_blank
      assign o_blank = (r_cyc < CYC_W'(BLANK_CYCLES));
    end
  endgenerate

  assign o_slot        = r_slot;
  assign o_pwm         = r_pwm;
  assign o_boundary    = w_cyc_last & w_slot_last;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode seven-segment scan driver with frame-synchronous write buffering,
// PWM brightness, per-digit enable, raw-segment mode and leading-zero suppression.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int  NUM_DIGITS   = 8,
  parameter int  DIGIT_CYCLES = 131072,
  parameter int  BLANK_CYCLES = 1024,
  parameter int  BRIGHT_W     = 4,
  localparam int SLOT_W       = $clog2(NUM_DIGITS)
) (
  input logic               clk,
  input logic               reset,
  seg_scan_driver_if.slave  bus
);
  logic [SLOT_W-1:0]     w_slot;
  logic [BRIGHT_W-1:0]   w_pwm;
  logic                  w_blank;
  logic                  w_boundary;
  logic                  w_frame_start;

  disp_cfg_t             w_wr_cfg [NUM_DIGITS];
  disp_cfg_t             r_buf    [NUM_DIGITS];
  disp_cfg_t             r_disp   [NUM_DIGITS];
  logic                  r_pending;

  logic [NUM_DIGITS-1:0] w_sup;
  logic                  w_run;
  logic                  w_lit;
  logic [NUM_DIGITS-1:0] w_an;
  logic [6:0]            w_seg;

  logic [NUM_DIGITS-1:0] r_an_p1;
  logic [6:0]            r_a2g_p1;
  logic                  r_dp_p1;

  seg_scan_driver_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .BRIGHT_W     (BRIGHT_W)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .o_slot        (w_slot),
    .o_pwm         (w_pwm),
    .o_blank       (w_blank),
    .o_boundary    (w_boundary),
    .o_frame_start (w_frame_start)
  );

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_wr_cfg[i].hex  = bus.wr_hex[4*i +: 4];
      w_wr_cfg[i].segs = bus.wr_segs[7*i +: 7];
      w_wr_cfg[i].dp   = bus.wr_dp[i];
      w_wr_cfg[i].en   = bus.wr_en[i];
      w_wr_cfg[i].raw  = bus.wr_raw;
      w_wr_cfg[i].lz   = bus.wr_lz;
    end
  end

  // A write in the boundary cycle stays pending: the old buffer is what gets applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_buf[i]  <= '0;
        r_disp[i] <= '0;
      end
      r_pending <= 1'b0;
    end else begin
      if (w_boundary && r_pending) r_disp <= r_buf;
      if (bus.wr_valid) begin
        r_buf     <= w_wr_cfg;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Suppress from the top digit down while digits are blank zeros; digit 0 always shows.
  always_comb begin
    w_sup = '0;
    w_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_run = w_run & r_disp[k].lz & ~r_disp[k].raw & (r_disp[k].hex == 4'h0) & ~r_disp[k].dp;
      w_sup[k] = w_run;
    end
  end

  assign w_lit = ~w_blank & r_disp[w_slot].en & ~w_sup[w_slot] &
                 ((&bus.brightness) | (w_pwm < bus.brightness));
  assign w_an  = ~(NUM_DIGITS'(1) << w_slot);
  assign w_seg = r_disp[w_slot].raw ? ~r_disp[w_slot].segs : hex2seg(r_disp[w_slot].hex);

  // Output stage: pins reflect the counter state of the previous cycle.
  always_ff @(posedge clk) begin
    if (reset || !w_lit) begin
      r_an_p1  <= '1;
      r_a2g_p1 <= SEG_OFF;
      r_dp_p1  <= 1'b1;
    end else begin
      r_an_p1  <= w_an;
      r_a2g_p1 <= w_seg;
      r_dp_p1  <= ~r_disp[w_slot].dp;
    end
  end

  assign bus.AN          = r_an_p1;
  assign bus.A2G         = r_a2g_p1;
  assign bus.DP          = r_dp_p1;
  assign bus.frame_start = w_frame_start;

endmodule
